// File: rtl/dpram_fifo_ctrl_pkg.sv
// rtl/dpram_fifo_ctrl_pkg.sv - shared sizing helpers for the dual-port RAM FIFO controller
package simple_rdma_fifo_pkg;

    localparam int OUT_DELAY_MAX = 4;

    function automatic int ob_depth(input int out_delay);
        return out_delay + 1;
    endfunction

    function automatic int cnt_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// rtl/dpram_fifo_ctrl_if.sv - stream and RAM-port bundle of the dual-port RAM FIFO controller
interface dpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int CW = simple_rdma_fifo_pkg::cnt_width(ADDR_WIDTH);

    logic                  i_s_valid;
    logic                  o_s_ready;
    logic [DATA_WIDTH-1:0] i_s_data;
    logic                  o_m_valid;
    logic                  i_m_ready;
    logic [DATA_WIDTH-1:0] o_m_data;
    logic [CW-1:0]         o_count;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_ram_we_a;
    logic [ADDR_WIDTH-1:0] o_ram_addr_a;
    logic [DATA_WIDTH-1:0] o_ram_data_a;
    logic                  o_ram_en_b;
    logic [ADDR_WIDTH-1:0] o_ram_addr_b;
    logic [DATA_WIDTH-1:0] i_ram_data_b;

    modport slave (
        input  i_s_valid, i_s_data, i_m_ready, i_ram_data_b,
        output o_s_ready, o_m_valid, o_m_data, o_count, o_full, o_empty,
               o_ram_we_a, o_ram_addr_a, o_ram_data_a, o_ram_en_b, o_ram_addr_b
    );

    modport master (
        output i_s_valid, i_s_data, i_m_ready, i_ram_data_b,
        input  o_s_ready, o_m_valid, o_m_data, o_count, o_full, o_empty,
               o_ram_we_a, o_ram_addr_a, o_ram_data_a, o_ram_en_b, o_ram_addr_b
    );
endinterface

// File: rtl/dpram_fifo_ctrl_obuf.sv
// rtl/dpram_fifo_ctrl_obuf.sv - small register FIFO absorbing RAM read latency
module dpram_fifo_obuf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  valid,
    output logic [CNT_W-1:0]      count
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         wr_idx;
    logic [IW-1:0]         rd_idx;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= idx_inc(wr_idx);
            end
            if (pop) rd_idx <= idx_inc(rd_idx);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_idx];
    assign valid = (count != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clr && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - valid/ready FIFO controller driving both ports of a dual-port RAM
module dpram_fifo_ctrl
    import simple_rdma_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 1024,
    parameter int OUT_DELAY  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    dpram_fifo_ctrl_if.slave bus
);
    localparam int OB_DEPTH = ob_depth(OUT_DELAY);
    localparam int CW       = cnt_width(ADDR_WIDTH);
    localparam int OBW      = $clog2(OUT_DELAY_MAX + 2);
    localparam int CRW      = OBW + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         ram_cnt, ram_cnt_nxt, count_q;
    logic [OUT_DELAY-1:0]  inflight;
    logic [OBW-1:0]        inflight_cnt, ob_cnt;
    logic [CRW-1:0]        credit_used;
    logic [DATA_WIDTH-1:0] ob_head;
    logic                  rst_done, full_q, s_ready;
    logic                  push, pop, issue, capture, ob_valid;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < OUT_DELAY; i++) inflight_cnt += OBW'(inflight[i]);
    end

    assign s_ready     = rst_done & ~full_q;
    assign push        = bus.i_s_valid & s_ready & ~i_flush;
    assign pop         = ob_valid & bus.i_m_ready;
    assign capture     = inflight[OUT_DELAY-1];
    // Words already owed to the output buffer; a read may only be issued while a slot remains.
    assign credit_used = CRW'(ob_cnt) + CRW'(inflight_cnt) - CRW'(pop);
    assign issue       = (ram_cnt != '0) && (credit_used < CRW'(OB_DEPTH)) && !i_flush;
    assign ram_cnt_nxt = ram_cnt + CW'(push) - CW'(issue);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_done <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            inflight <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (i_flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                ram_cnt  <= '0;
                inflight <= '0;
                count_q  <= '0;
                full_q   <= 1'b0;
            end else begin
                if (push)  wr_ptr <= ptr_inc(wr_ptr);
                if (issue) rd_ptr <= ptr_inc(rd_ptr);
                ram_cnt  <= ram_cnt_nxt;
                full_q   <= (ram_cnt_nxt == CW'(RAM_DEPTH));
                inflight <= (inflight << 1) | OUT_DELAY'(issue);
                count_q  <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    dpram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OB_DEPTH),
        .CNT_W      (OBW)
    ) u_obuf (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clr       (i_flush),
        .push      (capture),
        .push_data (bus.i_ram_data_b),
        .pop       (pop),
        .head      (ob_head),
        .valid     (ob_valid),
        .count     (ob_cnt)
    );

    assign bus.o_s_ready    = s_ready;
    assign bus.o_m_valid    = ob_valid;
    assign bus.o_m_data     = ob_head;
    assign bus.o_count      = count_q;
    assign bus.o_full       = full_q;
    assign bus.o_empty      = (count_q == '0);
    assign bus.o_ram_we_a   = push;
    assign bus.o_ram_addr_a = wr_ptr;
    assign bus.o_ram_data_a = rst_done ? bus.i_s_data : '0;
    assign bus.o_ram_en_b   = issue;
    assign bus.o_ram_addr_b = rd_ptr;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - self-checking bench: two controller configurations with RAM models and a queue scoreboard
module tb_dpram_fifo_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int NI = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          rst_q = 1'b0;

    logic [NI-1:0] m_valid, s_ready, full, empty;
    logic [DW-1:0] m_data [NI];
    logic [AW+1:0] count [NI];
    int            pops [NI];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst_n;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = (g == 0) ? 1 : 3;
        localparam int RD = (g == 0) ? 1024 : 1000;

        dpram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        logic [DW-1:0] mem [RD];
        logic [DW-1:0] pipe [D];
        logic [DW-1:0] q [$];

        dpram_fifo_ctrl #(
            .DATA_WIDTH (DW),
            .ADDR_WIDTH (AW),
            .RAM_DEPTH  (RD),
            .OUT_DELAY  (D)
        ) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_flush (flush),
            .bus     (bus)
        );

        assign bus.i_s_valid    = s_valid;
        assign bus.i_s_data     = s_data;
        assign bus.i_m_ready    = m_ready;
        assign bus.i_ram_data_b = pipe[D-1];
        assign m_valid[g]       = bus.o_m_valid;
        assign s_ready[g]       = bus.o_s_ready;
        assign full[g]          = bus.o_full;
        assign empty[g]         = bus.o_empty;
        assign m_data[g]        = bus.o_m_data;
        assign count[g]         = bus.o_count;

        // RAM with fixed read latency D
        always @(posedge clk) begin
            if (bus.o_ram_we_a) mem[bus.o_ram_addr_a] <= bus.o_ram_data_a;
            if (bus.o_ram_en_b) pipe[0] <= mem[bus.o_ram_addr_b];
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                check("rst_m_valid", bus.o_m_valid, 0);
                check("rst_m_data", bus.o_m_data, 0);
                check("rst_count", bus.o_count, 0);
                check("rst_empty", bus.o_empty, 1);
                check("rst_full", bus.o_full, 0);
                check("rst_s_ready", bus.o_s_ready, 0);
                check("rst_ram_ports", {bus.o_ram_we_a, bus.o_ram_addr_a, bus.o_ram_data_a,
                                        bus.o_ram_en_b, bus.o_ram_addr_b} == '0, 1);
            end else begin
                check("count", bus.o_count, q.size());
                check("empty", bus.o_empty, longint'(q.size() == 0));
                if (rst_q && q.size() < RD) check("ready_not_full", bus.o_s_ready, 1);
                if (bus.o_full) check("full_occupancy", longint'(q.size() >= RD), 1);
                if (q.size() >= RD + D + 1) check("full_when_packed", bus.o_full, 1);
                if (bus.o_m_valid) begin
                    if (q.size() == 0) check("m_valid_when_empty", 1, 0);
                    else check("m_data", bus.o_m_data, q[0]);
                end
                if (bus.o_m_valid && m_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    pops[g]++;
                end
                if (flush) q.delete();
                else if (s_valid && bus.o_s_ready) q.push_back(s_data);
            end
        end
    end

    int            first_c [NI];
    logic [DW-1:0] first_d [NI];
    int            snap [NI];
    logic          full_seen;

    task automatic clear_first();
        for (int g = 0; g < NI; g++) begin
            first_c[g] = -1;
            first_d[g] = '0;
        end
    endtask

    task automatic note_first(input int c);
        for (int g = 0; g < NI; g++)
            if (m_valid[g] && first_c[g] < 0) begin
                first_c[g] = c;
                first_d[g] = m_data[g];
            end
    endtask

    initial begin
        pops[0] = 0;
        pops[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int g = 0; g < NI; g++) check("ready_after_release", s_ready[g], 1);

        // First-word latency: push in cycle 0, valid in cycle OUT_DELAY+2
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        clear_first();
        for (int c = 1; c <= 8; c++) begin
            tick();
            s_valid = 1'b0;
            if (c == 1) for (int g = 0; g < NI; g++) check("lat_count_c1", count[g], 1);
            note_first(c);
        end
        check("lat_first_valid_d1", first_c[0], 3);
        check("lat_first_valid_d3", first_c[1], 5);
        for (int g = 0; g < NI; g++) begin
            check("lat_data", first_d[g], 32'hA5A5_0001);
            check("lat_empty_after", empty[g], 1);
        end

        // Full-rate stream of 2048 words
        snap = pops;
        full_seen = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
            full_seen |= full[0];
        end
        s_valid = 1'b0;
        repeat (8) tick();
        check("stream_no_full", full_seen, 0);
        check("stream_pops_d1", pops[0] - snap[0], 2048);
        check("stream_pops_d3", pops[1] - snap[1], 2048);

        // Fill to full with consumer stalled, then drain
        m_ready = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h1000_0000 + DW'(i);
            tick();
        end
        check("fill_count_d1", count[0], 1026);
        check("fill_count_d3", count[1], 1004);
        for (int g = 0; g < NI; g++) begin
            check("fill_full", full[g], 1);
            check("fill_s_ready", s_ready[g], 0);
        end
        s_valid = 1'b0;
        snap = pops;
        m_ready = 1'b1;
        repeat (1040) tick();
        check("drain_pops_d1", pops[0] - snap[0], 1026);
        check("drain_pops_d3", pops[1] - snap[1], 1004);
        for (int g = 0; g < NI; g++) check("drain_empty", empty[g], 1);

        // Random valid/ready traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (1100) tick();
        for (int g = 0; g < NI; g++) check("random_drained", empty[g], 1);

        // Flush with reads in flight; the flush-cycle push is dropped
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h200 + DW'(i);
            tick();
        end
        flush  = 1'b1;
        s_data = 32'hDEAD_BEEF;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            check("flush_count", count[g], 0);
            check("flush_m_valid", m_valid[g], 0);
        end
        s_valid = 1'b1;
        s_data  = 32'h55;
        tick();
        s_valid = 1'b0;
        clear_first();
        for (int c = 0; c < 10; c++) begin
            note_first(c);
            tick();
        end
        for (int g = 0; g < NI; g++) check("flush_next_word", first_d[g], 32'h55);

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h300 + DW'(i);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) begin
            check("async_m_valid", m_valid[g], 0);
            check("async_count", count[g], 0);
            check("async_empty", empty[g], 1);
            check("async_s_ready", s_ready[g], 0);
        end
        s_valid = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h77;
        m_ready = 1'b1;
        tick();
        tick();
        s_data = 32'h78;
        clear_first();
        for (int c = 0; c < 12; c++) begin
            note_first(c);
            tick();
            s_valid = 1'b0;
        end
        for (int g = 0; g < NI; g++) check("post_reset_first", first_d[g], 32'h77);
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
